// File: rtl/sig_dump_reader.sv
// Snoops CPU stores for halt/signature MMIO writes and, on halt, streams the
// signature region out of data memory over a valid/ready port.
module sig_dump_reader #(
    parameter int              XLEN           = 32,
    parameter int              AW             = 20,
    parameter logic [XLEN-1:0] ADDR_HALT      = XLEN'(32'h2000_0000),
    parameter logic [XLEN-1:0] ADDR_SIG_BEGIN = ADDR_HALT + XLEN'(XLEN / 8),
    parameter logic [XLEN-1:0] ADDR_SIG_END   = ADDR_HALT + XLEN'(2 * XLEN / 8)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_rd_addr,
    input  logic [XLEN-1:0] mem_rd_data,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last,
    output logic            busy,
    output logic            halted
);

    localparam int SH = $clog2(XLEN / 8);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] sig_begin;
    logic [AW-1:0] sig_end;
    logic [AW-1:0] ptr;

    logic [31:0]   store_shifted;
    logic [AW-1:0] store_word;
    logic          hit_begin;
    logic          hit_end;
    logic          hit_halt;
    logic          range_empty;

    // Byte address written by software becomes a memory word address.
    assign store_shifted = store_data[31:0] >> SH;
    assign store_word    = AW'(store_shifted);
    assign hit_begin     = store && (address == ADDR_SIG_BEGIN);
    assign hit_end       = store && (address == ADDR_SIG_END);
    assign hit_halt      = store && (address == ADDR_HALT) && (store_data[31:0] == 32'd1);
    assign range_empty   = (sig_end <= sig_begin);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sig_begin   <= '0;
            sig_end     <= '0;
            ptr         <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_last   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_begin) begin
                        sig_begin <= store_word;
                    end
                    if (hit_end) begin
                        sig_end <= store_word;
                    end
                    if (hit_halt) begin
                        if (range_empty) begin
                            halted <= 1'b1;
                            state  <= DONE;
                        end else begin
                            // Read request is issued as the READ state is entered so
                            // mem_rd_en is high for exactly the READ cycle.
                            ptr         <= sig_begin;
                            mem_rd_addr <= sig_begin;
                            mem_rd_en   <= 1'b1;
                            busy        <= 1'b1;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    dump_data  <= mem_rd_data;
                    dump_last  <= (ptr == sig_end - AW'(1));
                    dump_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_last) begin
                            busy   <= 1'b0;
                            halted <= 1'b1;
                            state  <= DONE;
                        end else begin
                            ptr         <= ptr + AW'(1);
                            mem_rd_addr <= ptr + AW'(1);
                            mem_rd_en   <= 1'b1;
                            state       <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
